noc_virtual_channel: RTL and testbench

Single input-port virtual channel for the NoC router: buffers incoming flits in a FIFO and exposes the packet header to route/allocation logic. Once the channel is allocated, it forwards the packet flit by flit under downstream backpressure. One instance sits per input VC, between the link receiver and the switch allocator/crossbar.

---
 rtl/noc_vc_pkg.sv | 31 +++
 rtl/noc_virtual_channel_if.sv | 23 ++
 rtl/noc_vc_fifo.sv | 46 ++++
 rtl/noc_virtual_channel.sv | 113 +++++++++++
 tb/tb_noc_virtual_channel.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_pkg.sv
// Shared definitions for the NoC input virtual channel: flit types, FSM encoding,
// and helpers for locating and classifying the flit type field.
package noc_vc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ALLOC = 2'd1,
        ST_ACTIVE     = 2'd2
    } vc_state_e;

    // The type field occupies the two MSBs of a flit.
    function automatic int unsigned type_lsb(input int unsigned data_w);
        return data_w - 2;
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/noc_virtual_channel_if.sv
// Link-side and crossbar-side signals of one input virtual channel.
interface noc_virtual_channel_if #(
    parameter int unsigned DATA_W = 10
);
    logic [DATA_W-1:0] data_i;
    logic              wr_en_i;
    logic              chan_alloc_i;
    logic              chan_rdy_i;
    logic [DATA_W-1:0] data_o;
    logic              data_vld_o;
    logic [DATA_W-1:0] header_o;
    logic              rdy_o;

    modport master (
        output data_i, wr_en_i, chan_alloc_i, chan_rdy_i,
        input  data_o, data_vld_o, header_o, rdy_o
    );

    modport slave (
        input  data_i, wr_en_i, chan_alloc_i, chan_rdy_i,
        output data_o, data_vld_o, header_o, rdy_o
    );
endinterface

// File: rtl/noc_vc_fifo.sv
// Show-ahead flit FIFO; full/empty distinguished by an extra pointer MSB.
module noc_vc_fifo #(
    parameter int unsigned DEPTH_W = 2,
    parameter int unsigned DATA_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);
    localparam int unsigned DEPTH = 1 << DEPTH_W;
    localparam int unsigned PTR_W = DEPTH_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                     (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[DEPTH_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/noc_virtual_channel.sv
// Input virtual channel: buffers flits, presents the packet header for allocation and
// forwards the packet once granted. Optional input protocol filter: NOC_VC_PROTOCOL_CHECK_EN.
module noc_virtual_channel
    import noc_vc_pkg::*;
#(
    parameter int unsigned VC_DEPTH_W = 2,
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned ID_W       = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    noc_virtual_channel_if.slave   bus
);
    localparam int unsigned TYPE_LSB = type_lsb(DATA_W);

    if (DATA_W < 2 + 2 * ID_W) begin : g_bad_width
        $error("noc_virtual_channel: DATA_W cannot hold type and destination");
    end

    vc_state_e         state;
    vc_state_e         state_nxt;
    logic [DATA_W-1:0] head_flit;
    logic [DATA_W-1:0] header_q;
    flit_type_e        head_type;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic              hdr_load;
    logic              fwd;

    assign head_type = flit_type_e'(head_flit[TYPE_LSB +: 2]);

`ifdef NOC_VC_PROTOCOL_CHECK_EN
    flit_type_e in_type;
    logic       pkt_open;
    logic       in_ok;

    // Headers only start a packet when none is open; body/tail only continue one.
    assign in_type   = flit_type_e'(bus.data_i[TYPE_LSB +: 2]);
    assign in_ok     = is_head(in_type) ? !pkt_open : pkt_open;
    assign fifo_push = bus.wr_en_i && !fifo_full && in_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_open <= 1'b0;
        end else if (fifo_push) begin
            if (in_type == FLIT_HEAD)      pkt_open <= 1'b1;
            else if (in_type == FLIT_TAIL) pkt_open <= 1'b0;
        end
    end
`else
    assign fifo_push = bus.wr_en_i && !fifo_full;
`endif

    noc_vc_fifo #(
        .DEPTH_W (VC_DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.data_i),
        .rdata (head_flit),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:       if (!fifo_empty && is_head(head_type)) state_nxt = ST_WAIT_ALLOC;
            ST_WAIT_ALLOC: if (bus.chan_alloc_i)                  state_nxt = ST_ACTIVE;
            ST_ACTIVE:     if (fwd && is_tail(head_type))         state_nxt = ST_IDLE;
            default:                                              state_nxt = ST_IDLE;
        endcase
    end

    // In IDLE a stray body/tail at the head is popped and dropped.
    always_comb begin
        fifo_pop = 1'b0;
        hdr_load = 1'b0;
        fwd      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                hdr_load = !fifo_empty && is_head(head_type);
                fifo_pop = !fifo_empty && !is_head(head_type);
            end
            ST_ACTIVE: begin
                fwd      = !fifo_empty && bus.chan_rdy_i;
                fifo_pop = fwd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         header_q <= '0;
        else if (hdr_load) header_q <= head_flit;
    end

    assign bus.data_vld_o = fwd;
    assign bus.data_o     = fwd ? head_flit : '0;
    assign bus.header_o   = (state == ST_IDLE) ? '0 : header_q;
    assign bus.rdy_o      = !fifo_full && !rst_i;

endmodule

// File: tb/tb_noc_virtual_channel.sv
// Scoreboard bench for noc_virtual_channel: directed packet scenarios plus random traffic
// checked against a flit-stream reference model.
module tb_noc_virtual_channel;
    localparam int unsigned DW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    noc_virtual_channel_if #(.DATA_W(DW)) bus ();

    noc_virtual_channel #(
        .VC_DEPTH_W (2),
        .DATA_W     (DW),
        .ID_W       (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] flit;
        logic [DW-1:0] hdr;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;
    bit            m_in_pkt = 1'b0;
    bit            m_open = 1'b0;
    logic [DW-1:0] m_hdr = '0;

    function automatic void check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    function automatic void check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, req);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    // Stream model: a flit leaves the channel if it opens a packet or lies inside one;
    // head/single open, tail/single close, stray body/tail outside a packet vanish.
    function automatic void model_accept(input logic [DW-1:0] f);
        logic [1:0] t;
        bit         store;
        bit         opener;
        bit         closer;
        t      = f[DW-1 -: 2];
        opener = (t == 2'b10) || (t == 2'b11);
        closer = (t == 2'b01) || (t == 2'b11);
        store  = 1'b1;
`ifdef NOC_VC_PROTOCOL_CHECK_EN
        store = opener ? !m_open : m_open;
        if (store && t == 2'b10) m_open = 1'b1;
        if (store && t == 2'b01) m_open = 1'b0;
`endif
        if (store && (m_in_pkt || opener)) begin
            if (!m_in_pkt) m_hdr = f;
            exp_q.push_back('{flit: f, hdr: m_hdr});
            m_in_pkt = !closer;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_open   = 1'b0;
        m_hdr    = '0;
    endfunction

    task automatic drive(input bit wr, input logic [DW-1:0] f, input bit alloc, input bit crdy);
        bus.wr_en_i      = wr;
        bus.data_i       = f;
        bus.chan_alloc_i = alloc;
        bus.chan_rdy_i   = crdy;
    endtask

    // Record a transfer when the upstream handshake completes at the coming edge.
    task automatic settle();
        @(negedge clk);
        if (bus.wr_en_i && bus.rdy_o) model_accept(bus.data_i);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit wr, input logic [DW-1:0] f, input bit alloc, input bit crdy);
        drive(wr, f, alloc, crdy);
        settle();
        advance();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_vld_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_flit: got %h, want no flit", bus.data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_vec("sb_data_o", bus.data_o, mon_e.flit);
                    check_vec("sb_header_o", bus.header_o, mon_e.hdr);
                end
            end else begin
                check_vec("idle_data_o", bus.data_o, '0);
            end
        end
    end

    initial begin
        logic [DW-1:0] rf;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("rst_data_o", bus.data_o, '0);
        check_bit("rst_data_vld_o", bus.data_vld_o, 1'b0);
        check_vec("rst_header_o", bus.header_o, '0);
        check_bit("rst_rdy_o", bus.rdy_o, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("rel_rdy_o", bus.rdy_o, 1'b1);
        check_vec("rel_header_o", bus.header_o, '0);
        check_bit("rel_data_vld_o", bus.data_vld_o, 1'b0);
        advance();

        // Single packet, grant two cycles after the head write.
        tick(1'b1, 10'h205, 1'b0, 1'b1);
        tick(1'b1, 10'h0AA, 1'b0, 1'b1);
        drive(1'b1, 10'h155, 1'b1, 1'b1); settle();
        check_vec("pkt_header_wait", bus.header_o, 10'h205); advance();
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_bit("pkt_vld0", bus.data_vld_o, 1'b1);
        check_vec("pkt_flit0", bus.data_o, 10'h205); advance();
        settle(); check_vec("pkt_flit1", bus.data_o, 10'h0AA); advance();
        settle(); check_vec("pkt_flit2", bus.data_o, 10'h155); advance();
        settle();
        check_vec("pkt_header_done", bus.header_o, '0);
        check_bit("pkt_vld_done", bus.data_vld_o, 1'b0); advance();

        // Fill the FIFO without a grant; the fifth write must be refused.
        tick(1'b1, 10'h2A1, 1'b0, 1'b1);
        tick(1'b1, 10'h012, 1'b0, 1'b1);
        tick(1'b1, 10'h013, 1'b0, 1'b1);
        drive(1'b1, 10'h114, 1'b0, 1'b1); settle();
        check_bit("full_rdy_before_4th", bus.rdy_o, 1'b1); advance();
        drive(1'b1, 10'h015, 1'b0, 1'b1); settle();
        check_bit("full_rdy_after_4th", bus.rdy_o, 1'b0); advance();
        tick(1'b0, '0, 1'b1, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_bit("full_rdy_recovered", bus.rdy_o, 1'b1);
        check_int("full_drained", exp_q.size(), 0); advance();

        // Backpressure in ACTIVE.
        tick(1'b1, 10'h230, 1'b0, 1'b1);
        tick(1'b1, 10'h031, 1'b0, 1'b1);
        tick(1'b1, 10'h132, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_bit("bp_vld_1", bus.data_vld_o, 1'b1); advance();
        drive(1'b0, '0, 1'b0, 1'b0); settle();
        check_bit("bp_vld_0", bus.data_vld_o, 1'b0); advance();
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_bit("bp_vld_resume", bus.data_vld_o, 1'b1);
        check_vec("bp_flit_resume", bus.data_o, 10'h031); advance();
        repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
        check_int("bp_drained", exp_q.size(), 0);

        // SINGLE followed by a new packet needing its own grant.
        tick(1'b1, 10'h30F, 1'b0, 1'b1);
        tick(1'b1, 10'h203, 1'b0, 1'b1);
        drive(1'b1, 10'h144, 1'b1, 1'b1); settle();
        check_vec("single_header", bus.header_o, 10'h30F); advance();
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_vec("single_flit", bus.data_o, 10'h30F); advance();
        settle();
        check_vec("single_back_idle", bus.header_o, '0);
        check_bit("single_idle_vld", bus.data_vld_o, 1'b0); advance();
        settle();
        check_vec("next_header", bus.header_o, 10'h203); advance();
        settle();
        check_bit("next_waits_grant", bus.data_vld_o, 1'b0); advance();
        tick(1'b0, '0, 1'b1, 1'b1);
        repeat (4) tick(1'b0, '0, 1'b0, 1'b1);
        check_int("single_drained", exp_q.size(), 0);

        // Stray BODY in IDLE never reaches the output.
        tick(1'b1, 10'h011, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_vec("stray_header", bus.header_o, '0);
        check_bit("stray_vld", bus.data_vld_o, 1'b0); advance();
        tick(1'b1, 10'h3C5, 1'b1, 1'b1);
        repeat (5) tick(1'b0, '0, 1'b1, 1'b1);
        check_int("stray_drained", exp_q.size(), 0);

        // Reset in the middle of a packet flushes the channel.
        tick(1'b1, 10'h2E2, 1'b0, 1'b1);
        tick(1'b1, 10'h023, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1); settle();
        check_vec("mid_header", bus.header_o, 10'h2E2); advance();
        rst = 1'b1;
        #1;
        check_vec("mid_rst_header", bus.header_o, '0);
        check_bit("mid_rst_rdy", bus.rdy_o, 1'b0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1'b1, 10'h3D6, 1'b1, 1'b1);
        repeat (5) tick(1'b0, '0, 1'b1, 1'b1);
        check_int("mid_rst_drained", exp_q.size(), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rf = {2'($urandom_range(0, 3)), 8'($urandom)};
            tick($urandom_range(0, 9) < 6, rf, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        repeat (40) tick(1'b0, '0, 1'b1, 1'b1);
        check_int("random_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
